bio_gpio_irq_apb: RTL
=====================

Name: bio_gpio_irq_apb

Overview:
Parametrised pad-side companion for the bio core. It places SYNC_STAGES-deep synchronisers on the GPIO inputs. It provides a per-pin software override mux on the core's GPIO output and direction. It also has an interrupt unit with per-line level/rising-edge mode, a sticky W1C status register and enable masking. All of this is programmed over APB. The block sits between the pads and the bio core, replacing the fixed 32-pin, 4-irq pass-through integration.

Parameters:
AW, 12, APB address width (>=6)
NGPIO, 32, GPIO pin count (1..32)
NIRQ, 4, core interrupt line count (1..32)
SYNC_STAGES, 2, input synchroniser depth (2..3)

Ports:
aclk  in  1  sole clock (APB and logic share it)
resetn  in  1  asynchronous active-low reset
gpio_in  in  NGPIO  raw pad inputs
gpio_in_sync  out  NGPIO  synchronised inputs to bio core
core_gpio_out  in  NGPIO  bio core output values
core_gpio_dir  in  NGPIO  bio core output enables
gpio_out  out  NGPIO  pad output values
gpio_dir  out  NGPIO  pad output enables (1 = drive)
core_irq  in  NIRQ  bio core interrupt sources
irq_out  out  NIRQ  masked per-line interrupts
irq_any  out  1  OR of irq_out
PADDR  in  AW  APB address
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PSTRB  in  4  APB byte strobes
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  APB ready
PSLVERR  out  1  APB error

Behaviour:
- Clock and reset: one clock, aclk. resetn is asynchronous, active-low. It clears every flop, including synchroniser stages, registers and edge history.
- Reset values: gpio_in_sync=0, irq_out=0, irq_any=0, PRDATA=0, PSLVERR=0. After reset gpio_out=core_gpio_out and gpio_dir=core_gpio_dir (override disabled).
- APB protocol: zero wait states; PREADY=1 constantly.
  - Write commits on the rising edge where PSEL&PENABLE&PWRITE. Each byte lane is gated by PSTRB.
  - Read data is combinational from registers while PSEL&~PWRITE.
  - Register address is PADDR[5:2]. PADDR[AW-1:6] must be 0, otherwise the address is unmapped.
  - Unmapped access, or a write to a read-only register: PSLVERR=1 in the access phase, PRDATA=0, no state change.
  - Register bits at or above NGPIO/NIRQ read 0 and ignore writes.
- Register map:
  - 0x00 IRQ_STATUS: RW1C, NIRQ bits.
  - 0x04 IRQ_ENABLE: RW, reset 0.
  - 0x08 IRQ_MODE: RW, reset 0. 0 = level, 1 = rising edge.
  - 0x0C GPIO_IN: RO, returns gpio_in_sync.
  - 0x10 OVR_EN: RW, reset 0.
  - 0x14 OVR_OUT: RW, reset 0.
  - 0x18 OVR_DIR: RW, reset 0.
  - 0x1C ID: RO, {16'hB10C, NIRQ[7:0], NGPIO[7:0]}.
- Synchroniser: SYNC_STAGES flop chain per pin. A gpio_in change appears on gpio_in_sync exactly SYNC_STAGES edges later. GPIO_IN reads the same value.
- Override mux (combinational), per pin i:
  - gpio_out[i] = OVR_EN[i] ? OVR_OUT[i] : core_gpio_out[i]
  - gpio_dir[i] = OVR_EN[i] ? OVR_DIR[i] : core_gpio_dir[i]
- IRQ history: irq_prev <= core_irq every cycle, regardless of mode.
- IRQ set condition, per line:
  - Level mode: set = core_irq.
  - Edge mode: set = core_irq & ~irq_prev.
- IRQ status update: status_next = set | (status & ~w1c_mask).
  - Set wins over a simultaneous W1C on the same bit.
  - Level mode with the source still high: clear is ineffective; the bit stays 1.
- IRQ outputs: irq_out = IRQ_STATUS & IRQ_ENABLE (combinational from registers); irq_any = |irq_out.
  - Latency: core_irq rising at edge N is seen in status after edge N+1, so irq_out asserts one cycle after the source.
  - Status bits latch even when the line is disabled. Enabling later asserts irq_out immediately.
- Mode change: IRQ_MODE writes do not alter status or irq_prev. A line already high when switched to edge mode does not fire until its next rise.
- Reset mid-operation: all status, history and synchroniser state clear. Outputs return to reset values asynchronously.

Test Plan:
1. Reset, then read 0x1C with NGPIO=32, NIRQ=4 -> PRDATA=0xB10C0420, PSLVERR=0. Read 0x00..0x18 -> 0. gpio_out/gpio_dir track core inputs.
2. gpio_in 0x0->0xA5A5A5A5 at edge N, SYNC_STAGES=2 -> gpio_in_sync=0 through edge N+1, 0xA5A5A5A5 after edge N+2. GPIO_IN reads the same.
3. Write OVR_EN=0x0F, OVR_OUT=0x05, OVR_DIR=0x0F with core_gpio_out=0xFFFFFFF0, core_gpio_dir=0 -> gpio_out=0xFFFFFFF5, gpio_dir=0x0000000F.
4. IRQ_MODE=0x1, IRQ_ENABLE=0x1, pulse core_irq[0] for 3 cycles -> IRQ_STATUS=0x1 from the cycle after the rise, irq_any=1. W1C 0x1 -> status 0. A second rise with a simultaneous W1C -> status stays 1.
5. Level line 1 held high, enable=0 -> status[1]=1, irq_out[1]=0. Write IRQ_ENABLE=0x2 -> irq_out[1]=1 next cycle. W1C while high -> remains 1. Drop source, then W1C -> 0.
6. Write to 0x0C, 0x20, or PADDR bit 6 set -> PSLVERR=1, PRDATA=0, no register change. PSTRB=0x1 write of 0xFFFFFFFF to OVR_OUT -> OVR_OUT=0x000000FF. Assert resetn=0 mid-transfer -> all outputs at reset values before the next clock.

Source files
------------

// File: rtl/bio_gpio_irq_apb_if.sv
// APB3/APB4 bus bundle for the bio GPIO/IRQ companion block.
// The master drives the request side; the slave returns data, ready and error.
interface bio_gpio_irq_apb_if #(
  parameter int AW = 12
) ();
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [3:0]    PSTRB;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PSTRB, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PSTRB, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/bio_gpio_irq_apb.sv
// Pad-side companion for the bio core: input synchronisers, per-pin software
// override of the core's output/direction, and a sticky interrupt unit with
// per-line level/rising-edge mode and enable masking, all behind APB.
module bio_gpio_irq_apb #(
  parameter int AW          = 12,
  parameter int NGPIO       = 32,
  parameter int NIRQ        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             aclk,
  input  logic             resetn,
  input  logic [NGPIO-1:0] gpio_in,
  output logic [NGPIO-1:0] gpio_in_sync,
  input  logic [NGPIO-1:0] core_gpio_out,
  input  logic [NGPIO-1:0] core_gpio_dir,
  output logic [NGPIO-1:0] gpio_out,
  output logic [NGPIO-1:0] gpio_dir,
  input  logic [NIRQ-1:0]  core_irq,
  output logic [NIRQ-1:0]  irq_out,
  output logic             irq_any,
  bio_gpio_irq_apb_if.slave apb
);

  localparam logic [3:0] IDX_STATUS  = 4'd0;
  localparam logic [3:0] IDX_ENABLE  = 4'd1;
  localparam logic [3:0] IDX_MODE    = 4'd2;
  localparam logic [3:0] IDX_GPIO_IN = 4'd3;
  localparam logic [3:0] IDX_OVR_EN  = 4'd4;
  localparam logic [3:0] IDX_OVR_OUT = 4'd5;
  localparam logic [3:0] IDX_OVR_DIR = 4'd6;
  localparam logic [3:0] IDX_ID      = 4'd7;

  localparam logic [7:0]  NIRQ_B  = 8'(NIRQ);
  localparam logic [7:0]  NGPIO_B = 8'(NGPIO);
  localparam logic [31:0] ID_VAL  = {16'hB10C, NIRQ_B, NGPIO_B};

  // Expand the four byte strobes into a 32-bit bit-enable mask.
  function automatic logic [31:0] f_strb_mask(input logic [3:0] strb);
    f_strb_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  // Registers
  logic [NGPIO-1:0] r_sync [SYNC_STAGES];
  logic [NIRQ-1:0]  r_irq_status;
  logic [NIRQ-1:0]  r_irq_en;
  logic [NIRQ-1:0]  r_irq_mode;
  logic [NIRQ-1:0]  r_irq_prev;
  logic [NGPIO-1:0] r_ovr_en;
  logic [NGPIO-1:0] r_ovr_out;
  logic [NGPIO-1:0] r_ovr_dir;

  // Decode / datapath wires
  logic [3:0]       w_idx;
  logic             w_unmapped;
  logic             w_ro;
  logic             w_access;
  logic             w_wr_ok;
  logic [31:0]      w_bmask;
  logic [NIRQ-1:0]  w_bm_irq;
  logic [NIRQ-1:0]  w_wd_irq;
  logic [NGPIO-1:0] w_bm_gpio;
  logic [NGPIO-1:0] w_wd_gpio;
  logic [NIRQ-1:0]  w_set;
  logic [NIRQ-1:0]  w_w1c;
  logic [NIRQ-1:0]  w_status_next;
  logic [31:0]      w_rdata;
  logic             w_unused_ok;

  // Byte offset bits never select a register; keep them visibly consumed.
  assign w_unused_ok = &{1'b0, apb.PADDR[1:0]};

  // Offsets 0x20..0x3F have no register, so bit 5 joins the high bits in the
  // unmapped check.
  assign w_idx      = apb.PADDR[5:2];
  assign w_unmapped = |apb.PADDR[AW-1:5];
  assign w_ro       = (w_idx == IDX_GPIO_IN) || (w_idx == IDX_ID);
  assign w_access   = apb.PSEL & apb.PENABLE;
  assign w_wr_ok    = w_access & apb.PWRITE & ~w_unmapped & ~w_ro;

  assign w_bmask   = f_strb_mask(apb.PSTRB);
  assign w_bm_irq  = w_bmask[NIRQ-1:0];
  assign w_wd_irq  = apb.PWDATA[NIRQ-1:0];
  assign w_bm_gpio = w_bmask[NGPIO-1:0];
  assign w_wd_gpio = apb.PWDATA[NGPIO-1:0];

  // Zero wait states; errors only flag in the access phase. Qualifying with
  // resetn keeps the bus outputs at their reset values while reset is held.
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = resetn & w_access & (w_unmapped | (apb.PWRITE & w_ro));
  assign apb.PRDATA  = (resetn & apb.PSEL & ~apb.PWRITE & ~w_unmapped) ? w_rdata : 32'h0000_0000;

  // Synchroniser chain: pad value reaches the core SYNC_STAGES edges later.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign gpio_in_sync = r_sync[SYNC_STAGES-1];

  // Software-programmable configuration registers with byte-lane writes.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_irq_en   <= '0;
      r_irq_mode <= '0;
      r_ovr_en   <= '0;
      r_ovr_out  <= '0;
      r_ovr_dir  <= '0;
    end else if (w_wr_ok) begin
      case (w_idx)
        IDX_ENABLE:  r_irq_en   <= (r_irq_en   & ~w_bm_irq)  | (w_wd_irq  & w_bm_irq);
        IDX_MODE:    r_irq_mode <= (r_irq_mode & ~w_bm_irq)  | (w_wd_irq  & w_bm_irq);
        IDX_OVR_EN:  r_ovr_en   <= (r_ovr_en   & ~w_bm_gpio) | (w_wd_gpio & w_bm_gpio);
        IDX_OVR_OUT: r_ovr_out  <= (r_ovr_out  & ~w_bm_gpio) | (w_wd_gpio & w_bm_gpio);
        IDX_OVR_DIR: r_ovr_dir  <= (r_ovr_dir  & ~w_bm_gpio) | (w_wd_gpio & w_bm_gpio);
        default: begin
        end
      endcase
    end
  end

  // Interrupt set and W1C terms; a fresh set always beats a same-cycle clear.
  always_comb begin
    w_set = (r_irq_mode & core_irq & ~r_irq_prev) | (~r_irq_mode & core_irq);
    if (w_wr_ok && (w_idx == IDX_STATUS)) begin
      w_w1c = w_wd_irq & w_bm_irq;
    end else begin
      w_w1c = '0;
    end
    w_status_next = w_set | (r_irq_status & ~w_w1c);
  end

  // Sticky status and source history; history tracks the source in every mode
  // so a mode switch never manufactures an edge.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_irq_status <= '0;
      r_irq_prev   <= '0;
    end else begin
      r_irq_status <= w_status_next;
      r_irq_prev   <= core_irq;
    end
  end

  // Register read mux; bits above NIRQ/NGPIO read as zero.
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_idx)
      IDX_STATUS:  w_rdata[NIRQ-1:0]  = r_irq_status;
      IDX_ENABLE:  w_rdata[NIRQ-1:0]  = r_irq_en;
      IDX_MODE:    w_rdata[NIRQ-1:0]  = r_irq_mode;
      IDX_GPIO_IN: w_rdata[NGPIO-1:0] = gpio_in_sync;
      IDX_OVR_EN:  w_rdata[NGPIO-1:0] = r_ovr_en;
      IDX_OVR_OUT: w_rdata[NGPIO-1:0] = r_ovr_out;
      IDX_OVR_DIR: w_rdata[NGPIO-1:0] = r_ovr_dir;
      IDX_ID:      w_rdata            = ID_VAL;
      default:     w_rdata            = 32'h0000_0000;
    endcase
  end

  // Per-pin override mux in front of the pads.
  assign gpio_out = (r_ovr_en & r_ovr_out) | (~r_ovr_en & core_gpio_out);
  assign gpio_dir = (r_ovr_en & r_ovr_dir) | (~r_ovr_en & core_gpio_dir);

  // Masked interrupt outputs straight from registers.
  assign irq_out = r_irq_status & r_irq_en;
  assign irq_any = |irq_out;

endmodule
